game_cell_painter: RTL and testbench

//  Downstream of the snake game FSM: converts one 16x16 game-grid cell plot request (game_x, game_y,

---
 rtl/game_cell_painter_if.sv | 26 ++
 rtl/game_cell_painter.sv | 103 ++++++++++
 tb/tb_game_cell_painter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/game_cell_painter_if.sv
// Request/pixel bundle between the snake game FSM and the cell painter.
// Handshake: a request (clear or game_plot) is taken on a rising edge where waitrequest=0; the requester holds it until then.
interface game_cell_painter_if;
  logic       game_plot;
  logic [3:0] game_x;
  logic [3:0] game_y;
  logic [2:0] game_colour;
  logic       clear;
  logic [2:0] clear_colour;
  logic       waitrequest;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [1:0] state_dbg;

  modport master (
    output game_plot, game_x, game_y, game_colour, clear, clear_colour,
    input  waitrequest, vga_x, vga_y, vga_colour, vga_plot, state_dbg
  );

  modport slave (
    input  game_plot, game_x, game_y, game_colour, clear, clear_colour,
    output waitrequest, vga_x, vga_y, vga_colour, vga_plot, state_dbg
  );
endinterface

// File: rtl/game_cell_painter.sv
// Expands one 16x16 grid-cell plot (or a full-board clear) into a raster of
// single-pixel writes on the 160x120 VGA adapter, one pixel per clock.
module game_cell_painter #(
  parameter int CELL_SIZE = 6,
  parameter int X_ORIGIN  = 32,
  parameter int Y_ORIGIN  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  game_cell_painter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CELL  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [7:0] X_ORG      = 8'(X_ORIGIN);
  localparam logic [6:0] Y_ORG      = 7'(Y_ORIGIN);
  localparam logic [7:0] CSZ_X      = 8'(CELL_SIZE);
  localparam logic [6:0] CSZ_Y      = 7'(CELL_SIZE);
  localparam logic [6:0] CELL_LAST  = 7'(CELL_SIZE - 1);
  localparam logic [6:0] BOARD_LAST = 7'(16 * CELL_SIZE - 1);

  state_t     state;
  logic [6:0] px;
  logic [6:0] py;
  logic [6:0] last;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [7:0] cell_x;
  logic [6:0] cell_y;

  // Cell origin on screen; products stay inside 8/7 bits for a 16-cell board.
  assign cell_x = X_ORG + ({4'd0, bus.game_x} * CSZ_X);
  assign cell_y = Y_ORG + ({3'd0, bus.game_y} * CSZ_Y);

  assign bus.waitrequest = (state != IDLE);
  assign bus.state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      px             <= '0;
      py             <= '0;
      last           <= '0;
      base_x         <= '0;
      base_y         <= '0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.vga_plot <= 1'b0;
          px           <= '0;
          py           <= '0;
          // Clear has priority; a simultaneous plot stays pending at the requester.
          if (bus.clear) begin
            state          <= CLEAR;
            last           <= BOARD_LAST;
            base_x         <= X_ORG;
            base_y         <= Y_ORG;
            bus.vga_x      <= X_ORG;
            bus.vga_y      <= Y_ORG;
            bus.vga_colour <= bus.clear_colour;
            bus.vga_plot   <= 1'b1;
          end else if (bus.game_plot) begin
            state          <= CELL;
            last           <= CELL_LAST;
            base_x         <= cell_x;
            base_y         <= cell_y;
            bus.vga_x      <= cell_x;
            bus.vga_y      <= cell_y;
            bus.vga_colour <= bus.game_colour;
            bus.vga_plot   <= 1'b1;
          end
        end
        CELL, CLEAR: begin
          if (px == last && py == last) begin
            state        <= IDLE;
            bus.vga_plot <= 1'b0;
          end else if (px == last) begin
            px        <= '0;
            py        <= py + 7'd1;
            bus.vga_x <= base_x;
            bus.vga_y <= base_y + py + 7'd1;
          end else begin
            px        <= px + 7'd1;
            bus.vga_x <= base_x + {1'b0, px} + 8'd1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.vga_plot <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_cell_painter.sv
// Directed bench for game_cell_painter: pixel scoreboard fed from hand-computed
// cell/board rasters, plus busy-length and back-to-back spacing checks.
module tb_game_cell_painter;

  logic clk;
  logic rst_n;
  game_cell_painter_if bus ();

  game_cell_painter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_busy;
  logic [17:0] exp_q[$];
  int          start_q[$];
  logic [17:0] last_pix;
  logic        prev_plot = 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of exp_q
  always @(negedge clk) begin
    logic [17:0] pix;
    check("wr_eq_plot", {31'd0, bus.waitrequest}, {31'd0, bus.vga_plot});
    if (bus.vga_plot) begin
      pix = {bus.vga_x, bus.vga_y, bus.vga_colour};
      last_pix = pix;
      if (!prev_plot) start_q.push_back(cyc);
      check("pix_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("pix", {14'd0, pix}, {14'd0, exp_q.pop_front()});
    end
    prev_plot = bus.vga_plot;
  end

  task automatic push_cell(input int cx, input int cy, input logic [2:0] c);
    for (int py = 0; py < 6; py++)
      for (int px = 0; px < 6; px++)
        exp_q.push_back({8'(32 + cx * 6 + px), 7'(12 + cy * 6 + py), c});
  endtask

  task automatic push_board(input logic [2:0] c);
    for (int py = 0; py < 96; py++)
      for (int px = 0; px < 96; px++)
        exp_q.push_back({8'(32 + px), 7'(12 + py), c});
  endtask

  // drivers (called right after a negedge)
  task automatic drive_plot(input logic [3:0] x, input logic [3:0] y, input logic [2:0] c);
    bus.game_plot   = 1'b1;
    bus.game_x      = x;
    bus.game_y      = y;
    bus.game_colour = c;
  endtask

  task automatic wait_busy(input int budget, output int n);
    n = 0;
    while (bus.waitrequest && n < budget) begin
      n++;
      @(negedge clk);
    end
    check("busy_timeout", {31'd0, bus.waitrequest}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.game_plot = 1'b0; bus.game_x = '0; bus.game_y = '0; bus.game_colour = '0;
    bus.clear = 1'b0; bus.clear_colour = '0;
    repeat (3) @(negedge clk);
    check("rst_wr",     {31'd0, bus.waitrequest}, 32'd0);
    check("rst_plot",   {31'd0, bus.vga_plot},    32'd0);
    check("rst_x",      {24'd0, bus.vga_x},       32'd0);
    check("rst_y",      {25'd0, bus.vga_y},       32'd0);
    check("rst_colour", {29'd0, bus.vga_colour},  32'd0);
    check("rst_state",  {30'd0, bus.state_dbg},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // cell (0,0) red
    push_cell(0, 0, 3'b001);
    drive_plot(4'd0, 4'd0, 3'b001);
    @(negedge clk);
    bus.game_plot = 1'b0;
    check("c00_busy", {31'd0, bus.waitrequest}, 32'd1);
    wait_busy(100, n_busy);
    check("c00_len", n_busy, 32'd36);
    check("c00_last", {14'd0, last_pix}, {14'd0, 8'd37, 7'd17, 3'b001});

    // cell (15,15) white: corner of the playfield
    push_cell(15, 15, 3'b111);
    drive_plot(4'd15, 4'd15, 3'b111);
    @(negedge clk);
    bus.game_plot = 1'b0;
    check("c1515_first", {14'd0, bus.vga_x, bus.vga_y, bus.vga_colour}, {14'd0, 8'd122, 7'd102, 3'b111});
    wait_busy(100, n_busy);
    check("c1515_len", n_busy, 32'd36);
    check("c1515_last", {14'd0, last_pix}, {14'd0, 8'd127, 7'd107, 3'b111});
    check("c1515_hold_x", {24'd0, bus.vga_x}, 32'd127);

    // back-to-back (8,8) then (7,1) with game_plot held
    push_cell(8, 8, 3'b010);
    push_cell(7, 1, 3'b100);
    drive_plot(4'd8, 4'd8, 3'b010);
    @(negedge clk);
    bus.game_x = 4'd7; bus.game_y = 4'd1; bus.game_colour = 3'b100;
    wait_busy(100, n_busy);
    check("b2b_len0", n_busy, 32'd36);
    @(negedge clk);
    check("b2b_accept", {31'd0, bus.waitrequest}, 32'd1);
    bus.game_plot = 1'b0;
    wait_busy(100, n_busy);
    check("b2b_len1", n_busy, 32'd36);
    check("b2b_gap", start_q[$] - start_q[$-1], 32'd37);

    // clear and plot together: clear first, plot right after
    push_board(3'b000);
    push_cell(3, 4, 3'b101);
    bus.clear = 1'b1; bus.clear_colour = 3'b000;
    drive_plot(4'd3, 4'd4, 3'b101);
    @(negedge clk);
    bus.clear = 1'b0;
    check("clr_first", {14'd0, bus.vga_x, bus.vga_y, bus.vga_colour}, {14'd0, 8'd32, 7'd12, 3'b000});
    wait_busy(10000, n_busy);
    check("clr_len", n_busy, 32'd9216);
    check("clr_last", {14'd0, last_pix}, {14'd0, 8'd127, 7'd107, 3'b000});
    @(negedge clk);
    check("clr_then_cell", {31'd0, bus.waitrequest}, 32'd1);
    bus.game_plot = 1'b0;
    wait_busy(100, n_busy);
    check("clr_cell_len", n_busy, 32'd36);
    check("clr_gap", start_q[$] - start_q[$-1], 32'd9217);

    // inputs changed while busy are ignored
    push_cell(2, 9, 3'b011);
    drive_plot(4'd2, 4'd9, 3'b011);
    @(negedge clk);
    bus.game_plot = 1'b0;
    repeat (4) begin
      bus.game_x = 4'($urandom_range(0, 15));
      bus.game_y = 4'($urandom_range(0, 15));
      bus.game_colour = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    wait_busy(100, n_busy);
    check("latch_len", n_busy, 32'd32);
    check("latch_last", {14'd0, last_pix}, {14'd0, 8'd49, 7'd71, 3'b011});

    // asynchronous reset mid-cell: three pixels appear, then abort
    exp_q.push_back({8'd62, 7'd42, 3'b110});
    exp_q.push_back({8'd63, 7'd42, 3'b110});
    exp_q.push_back({8'd64, 7'd42, 3'b110});
    drive_plot(4'd5, 4'd5, 3'b110);
    @(negedge clk);
    bus.game_plot = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_plot", {31'd0, bus.vga_plot},    32'd0);
    check("arst_wr",   {31'd0, bus.waitrequest}, 32'd0);
    check("arst_q",    exp_q.size(),             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", {30'd0, bus.state_dbg}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
